bp_me_wormhole_packet_serializer: RTL and testbench



---
 rtl/bp_me_wormhole_packet_serializer_pkg.sv | 20 ++
 rtl/bp_me_wormhole_packet_serializer_if.sv | 33 +++
 rtl/bp_me_wormhole_flit_select.sv | 31 +++
 rtl/bp_me_wormhole_packet_serializer.sv | 129 ++++++++++++
 tb/tb_bp_me_wormhole_packet_serializer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/bp_me_wormhole_packet_serializer_pkg.sv
// ---------------------------------------------------------------------------
// bp_me_pkg
//   Shared types and helpers for the mem-response wormhole serializer path.
//   - bp_me_wormhole_ser_state_e : serializer FSM states
//   - bp_me_max_flits()          : number of flits needed to carry a packet
// ---------------------------------------------------------------------------
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_send = 1'b1
    } bp_me_wormhole_ser_state_e;

    // Ceiling division: flits needed to cover packet_width bits.
    function automatic int unsigned bp_me_max_flits(input int unsigned packet_width,
                                                    input int unsigned flit_width);
        return (packet_width + flit_width - 32'd1) / flit_width;
    endfunction

endpackage

// File: rtl/bp_me_wormhole_packet_serializer_if.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_packet_serializer_if
//   Bundles the packet-side and link-side handshakes of the serializer.
//   Signal suffixes are from the serializer's point of view.
//   Ports (slave = serializer):
//     packet_i / packet_v_i / packet_ready_o : packet input handshake
//     link_data_o / link_v_o / link_ready_i  : flit output handshake
//     len_err_o                              : sticky oversize-len flag
//   modport master : upstream encoder + downstream link (drives packet, ready)
//   modport slave  : the serializer itself
// ---------------------------------------------------------------------------
interface bp_me_wormhole_packet_serializer_if #(
    parameter int flit_width_p   = 64,
    parameter int packet_width_p = 320
);
    logic [packet_width_p-1:0] packet_i;
    logic                      packet_v_i;
    logic                      packet_ready_o;
    logic [flit_width_p-1:0]   link_data_o;
    logic                      link_v_o;
    logic                      link_ready_i;
    logic                      len_err_o;

    modport master (
        output packet_i, packet_v_i, link_ready_i,
        input  packet_ready_o, link_data_o, link_v_o, len_err_o
    );

    modport slave (
        input  packet_i, packet_v_i, link_ready_i,
        output packet_ready_o, link_data_o, link_v_o, len_err_o
    );
endinterface

// File: rtl/bp_me_wormhole_flit_select.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_flit_select
//   Combinational flit picker: returns flit (cnt_i mod max_flits_p) of the
//   zero-padded packet. The modulo keeps an over-long index inside the padded
//   register, so out-of-range flits read back as padding or wrap around.
//   Ports:
//     data_i : padded packet, max_flits_p*flit_width_p bits
//     cnt_i  : flit index
//     flit_o : selected flit
// ---------------------------------------------------------------------------
module bp_me_wormhole_flit_select #(
    parameter int flit_width_p = 64,
    parameter int max_flits_p  = 5,
    parameter int cnt_width_p  = 4
) (
    input  logic [max_flits_p*flit_width_p-1:0] data_i,
    input  logic [cnt_width_p-1:0]              cnt_i,
    output logic [flit_width_p-1:0]             flit_o
);
    localparam int idx_width_lp = (max_flits_p > 1) ? $clog2(max_flits_p) : 1;

    logic [31:0]             idx_full_s;
    logic [idx_width_lp-1:0] idx_s;

    // Fold the counter into the padded range and slice out the flit.
    always_comb begin
        idx_full_s = 32'(cnt_i) % 32'(max_flits_p);
        idx_s      = idx_full_s[idx_width_lp-1:0];
        flit_o     = data_i[idx_s*flit_width_p +: flit_width_p];
    end
endmodule

// File: rtl/bp_me_wormhole_packet_serializer.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_packet_serializer
//   Registers one wormhole packet {payload, len, cord} and emits it as len+1
//   flits, lowest flit first, on a ready/valid link. A new packet can be taken
//   on the last flit handshake of the current one, so there is no bubble.
//   Ports:
//     clk_i     : clock
//     reset_n_i : asynchronous active-low reset
//     ser_if    : slave modport (packet_i/_v_i/_ready_o, link_data_o/_v_o/
//                 link_ready_i, len_err_o)
//   Optional build macro BP_ME_WORMHOLE_SER_LEN_CLAMP_EN: clamps an oversize
//   len to max_flits_lp-1 and raises sticky len_err_o. Without it len is used
//   as received and len_err_o is 0.
// ---------------------------------------------------------------------------
module bp_me_wormhole_packet_serializer
    import bp_me_pkg::*;
#(
    parameter int flit_width_p   = 64,
    parameter int cord_width_p   = 7,
    parameter int len_width_p    = 4,
    parameter int packet_width_p = 320
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    bp_me_wormhole_packet_serializer_if.slave    ser_if
);
    localparam int max_flits_lp    = int'(bp_me_max_flits(packet_width_p, flit_width_p));
    localparam int padded_width_lp = max_flits_lp * flit_width_p;

    bp_me_wormhole_ser_state_e   state_q;
    logic [len_width_p-1:0]      cnt_q;
    logic [len_width_p-1:0]      len_q;
    logic [padded_width_lp-1:0]  packet_q;
    logic                        ready_en_q;   // holds packet_ready_o low through reset

    logic [padded_width_lp-1:0]  packet_pad_s;
    logic [len_width_p-1:0]      len_raw_s;
    logic [len_width_p-1:0]      len_in_s;
    logic                        last_s;
    logic                        flit_hs_s;
    logic                        packet_ready_s;
    logic                        accept_s;

`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
    localparam logic [len_width_p-1:0] max_len_lp = len_width_p'(max_flits_lp - 1);
    logic                        len_over_s;
    logic                        len_err_q;
`endif

    // Zero-pad the incoming packet and extract (optionally clamp) its len.
    always_comb begin
        packet_pad_s                     = '0;
        packet_pad_s[packet_width_p-1:0] = ser_if.packet_i;
        len_raw_s                        = ser_if.packet_i[cord_width_p +: len_width_p];
`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
        len_over_s = (len_raw_s > max_len_lp);
        if (len_over_s) begin
            len_in_s = max_len_lp;
        end else begin
            len_in_s = len_raw_s;
        end
`else
        len_in_s = len_raw_s;
`endif
    end

    // Handshake decode; ready in e_send comes straight from link_ready_i so the
    // next packet loads on the same edge that retires the last flit.
    always_comb begin
        last_s    = (cnt_q == len_q);
        flit_hs_s = (state_q == e_send) & ser_if.link_ready_i;
        case (state_q)
            e_idle:  packet_ready_s = ready_en_q;
            e_send:  packet_ready_s = last_s & ser_if.link_ready_i;
            default: packet_ready_s = 1'b0;
        endcase
        accept_s = ser_if.packet_v_i & packet_ready_s;
    end

    // Serializer FSM: packet register, flit counter and state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            cnt_q      <= '0;
            len_q      <= '0;
            packet_q   <= '0;
            ready_en_q <= 1'b0;
`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
            len_err_q  <= 1'b0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            if (accept_s) begin
                state_q  <= e_send;
                packet_q <= packet_pad_s;
                len_q    <= len_in_s;
                cnt_q    <= '0;
`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
                len_err_q <= len_err_q | len_over_s;
`endif
            end else if (flit_hs_s) begin
                if (last_s) begin
                    state_q <= e_idle;
                end else begin
                    cnt_q <= cnt_q + len_width_p'(1);
                end
            end
        end
    end

    bp_me_wormhole_flit_select #(
        .flit_width_p (flit_width_p),
        .max_flits_p  (max_flits_lp),
        .cnt_width_p  (len_width_p)
    ) u_flit_select (
        .data_i (packet_q),
        .cnt_i  (cnt_q),
        .flit_o (ser_if.link_data_o)
    );

    assign ser_if.link_v_o       = (state_q == e_send);
    assign ser_if.packet_ready_o = packet_ready_s;
`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
    assign ser_if.len_err_o      = len_err_q;
`else
    assign ser_if.len_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_wormhole_packet_serializer.sv
// ---------------------------------------------------------------------------
// tb_bp_me_wormhole_packet_serializer
//   Directed + randomized bench for the wormhole packet serializer
//   (flit 64, cord 7, len 4, packet 320 => 5 flits). Expected flits come from
//   a reference model that shifts the packet by 64*k and keeps a queue of
//   outstanding flits per packet.
// ---------------------------------------------------------------------------
module tb_bp_me_wormhole_packet_serializer;
    localparam int FW = 64;
    localparam int PW = 320;
    localparam int MAXF = 5;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    bit   exp_len_err;
    logic [PW-1:0] pend_q[$];

    bp_me_wormhole_packet_serializer_if #(.flit_width_p(FW), .packet_width_p(PW)) ser_if ();

    bp_me_wormhole_packet_serializer #(
        .flit_width_p   (FW),
        .cord_width_p   (7),
        .len_width_p    (4),
        .packet_width_p (PW)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .ser_if    (ser_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt(input int len);
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom();
        p[10:7] = 4'(len);
        return p;
    endfunction

    function automatic int model_len(input logic [PW-1:0] p);
        int l;
        l = int'(p[10:7]);
`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
        if (l > MAXF - 1) l = MAXF - 1;
`endif
        return l;
    endfunction

    function automatic logic [FW-1:0] model_flit(input logic [PW-1:0] p, input int k);
        logic [PW-1:0] sh;
        sh = p >> (FW * (k % MAXF));
        return sh[FW-1:0];
    endfunction

    // Offer every packet in pend_q and check every cycle against the model.
    // mode 0: link always ready; 1: ready pattern 1,0,0,...; 2: random ready.
    task automatic stream(input int mode);
        logic [FW-1:0] cur_q[$];
        logic [PW-1:0] p;
        int  c;
        bit  busy, exp_rdy, lr;
        c = 0;
        while ((pend_q.size() > 0 || cur_q.size() > 0) && c < 300) begin
            @(posedge clk); #1;
            ser_if.packet_v_i = (pend_q.size() > 0);
            ser_if.packet_i   = (pend_q.size() > 0) ? pend_q[0] : rand_pkt($urandom_range(0, 4));
            case (mode)
                0:       lr = 1'b1;
                1:       lr = ((c % 3) == 0);
                default: lr = 1'($urandom_range(0, 1));
            endcase
            ser_if.link_ready_i = lr;
            #1;
            busy    = (cur_q.size() > 0);
            exp_rdy = busy ? ((cur_q.size() == 1) && lr) : 1'b1;
            check("link_v", ser_if.link_v_o, busy);
            if (busy) check("link_data", ser_if.link_data_o, cur_q[0]);
            check("packet_ready", ser_if.packet_ready_o, exp_rdy);
            check("len_err", ser_if.len_err_o, exp_len_err);
            if (busy && lr) void'(cur_q.pop_front());
            if (ser_if.packet_v_i && exp_rdy) begin
                p = pend_q.pop_front();
                for (int k = 0; k <= model_len(p); k++) cur_q.push_back(model_flit(p, k));
`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
                if (int'(p[10:7]) > MAXF - 1) exp_len_err = 1'b1;
`endif
            end
            c++;
        end
        if (c >= 300) check("stream_timeout", 64'(c), 64'd0);
        pend_q.delete();
        @(posedge clk); #1;
        ser_if.packet_v_i   = 1'b0;
        ser_if.link_ready_i = 1'($urandom_range(0, 1));
        #1;
        check("idle_link_v", ser_if.link_v_o, 1'b0);
        check("idle_packet_ready", ser_if.packet_ready_o, 1'b1);
    endtask

    initial begin
        logic [PW-1:0] p;
        n_checks            = 0;
        n_errors            = 0;
        exp_len_err         = 1'b0;
        reset_n             = 1'b0;
        ser_if.packet_i     = '0;
        ser_if.packet_v_i   = 1'b0;
        ser_if.link_ready_i = 1'b0;

        // Reset state.
        #12;
        check("rst_link_v", ser_if.link_v_o, 1'b0);
        check("rst_packet_ready", ser_if.packet_ready_o, 1'b0);
        check("rst_len_err", ser_if.len_err_o, 1'b0);
        check("rst_link_data", ser_if.link_data_o, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #2;
        check("post_rst_ready", ser_if.packet_ready_o, 1'b1);

        // Single-flit ack packet.
        pend_q.push_back(rand_pkt(0));
        stream(0);

        // Full 5-flit data packet, then same packet with a stalling link.
        p = rand_pkt(4);
        pend_q.push_back(p);
        stream(0);
        pend_q.push_back(p);
        stream(1);

        // Back-to-back: len 2 then len 0.
        pend_q.push_back(rand_pkt(2));
        pend_q.push_back(rand_pkt(0));
        stream(0);

        // Reset mid-packet during flit 2.
        p = rand_pkt(4);
        @(posedge clk); #1;
        ser_if.packet_i     = p;
        ser_if.packet_v_i   = 1'b1;
        ser_if.link_ready_i = 1'b1;
        @(posedge clk); #1;
        ser_if.packet_v_i = 1'b0;
        #1;
        check("mid_flit0", ser_if.link_data_o, model_flit(p, 0));
        @(posedge clk); #2;
        check("mid_flit1", ser_if.link_data_o, model_flit(p, 1));
        @(posedge clk); #2;
        check("mid_flit2", ser_if.link_data_o, model_flit(p, 2));
        check("mid_link_v", ser_if.link_v_o, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_link_v", ser_if.link_v_o, 1'b0);
        check("mid_rst_ready", ser_if.packet_ready_o, 1'b0);
        check("mid_rst_data", ser_if.link_data_o, 64'd0);
        @(posedge clk); #3;
        reset_n     = 1'b1;
        exp_len_err = 1'b0;
        pend_q.push_back(rand_pkt(3));
        stream(0);

        // Randomized packets with a random link.
        for (int i = 0; i < 8; i++) pend_q.push_back(rand_pkt($urandom_range(0, 4)));
        stream(2);

`ifdef BP_ME_WORMHOLE_SER_LEN_CLAMP_EN
        // Oversize len is clamped to 5 flits and len_err stays set until reset.
        pend_q.push_back(rand_pkt(9));
        stream(0);
        pend_q.push_back(rand_pkt(1));
        stream(2);
        check("len_err_sticky", ser_if.len_err_o, 1'b1);
        reset_n = 1'b0;
        #1;
        check("len_err_rst", ser_if.len_err_o, 1'b0);
        @(posedge clk); #3;
        reset_n     = 1'b1;
        exp_len_err = 1'b0;
        pend_q.push_back(rand_pkt(2));
        stream(0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
